// File: rtl/pio_write_arbiter.sv
// Two-requester arbiter for the PIO output register write port.
// Merges byte-masked writes against a shadow copy and issues a one-cycle strobe.
module pio_write_arbiter #(
  parameter int DW         = 32,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_LIM = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [DW-1:0]   data0,
  input  logic [DW/8-1:0] mask0,
  input  logic            req1,
  input  logic [DW-1:0]   data1,
  input  logic [DW/8-1:0] mask1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            pio_en,
  output logic [DW-1:0]   pio_data,
  output logic [DW-1:0]   shadow,
  output logic            busy
);

  localparam int MW = DW / 8;
  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  // Handshake: req is a level held until the matching gnt pulse; gnt, pio_en
  // and busy all coincide in the single WRITE cycle that commits the write.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   lat_data;
  logic [MW-1:0]   lat_mask;
  logic            lat_id;
  logic            last_winner;
  logic [7:0]      starve_cnt;
  logic [DW-1:0]   shadow_q;
  logic [DW-1:0]   mask_bits;
  logic [DW-1:0]   merged;
  logic            any_req;
  logic            win_id;

  assign any_req = req0 | req1;

  // Winner selection for the current IDLE cycle.
  always_comb begin
    win_id = 1'b0;
    if (PRIO_MODE == 0) begin
      if (req0 && req1) win_id = ~last_winner;
      else              win_id = req1;
    end else begin
      if (req1 && (!req0 || starve_cnt == LIM)) win_id = 1'b1;
    end
  end

  for (genvar b = 0; b < MW; b++) begin : g_mask
    assign mask_bits[8*b +: 8] = {8{lat_mask[b]}};
  end

  assign merged = (shadow_q & ~mask_bits) | (lat_data & mask_bits);

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    pio_en     = 1'b0;
    busy       = 1'b0;
    pio_data   = '0;
    case (state)
      IDLE: begin
        if (any_req) state_next = WRITE;
      end
      WRITE: begin
        state_next = IDLE;
        pio_en     = 1'b1;
        busy       = 1'b1;
        pio_data   = merged;
        gnt0       = ~lat_id;
        gnt1       = lat_id;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_data    <= '0;
      lat_mask    <= '0;
      lat_id      <= 1'b0;
      last_winner <= 1'b1;
      shadow_q    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        lat_data <= win_id ? data1 : data0;
        lat_mask <= win_id ? mask1 : mask0;
        lat_id   <= win_id;
      end
      if (state == WRITE) begin
        shadow_q    <= merged;
        last_winner <= lat_id;
      end
    end
  end

  // Counts how long requester 1 has been kept waiting; only used in fixed priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (PRIO_MODE != 0) begin
      if (!req1 || gnt1)      starve_cnt <= '0;
      else if (starve_cnt != LIM) starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign shadow = shadow_q;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Bench for pio_write_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios followed by random traffic against a transaction-level model.
module tb_pio_write_arbiter;

  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 4;

  logic          clk;
  logic          rst;
  logic          req0_a [2];
  logic          req1_a [2];
  logic [DW-1:0] data0_a [2];
  logic [DW-1:0] data1_a [2];
  logic [MW-1:0] mask0_a [2];
  logic [MW-1:0] mask1_a [2];
  logic          gnt0_w [2];
  logic          gnt1_w [2];
  logic          pio_en_w [2];
  logic          busy_w [2];
  logic [DW-1:0] pio_data_w [2];
  logic [DW-1:0] shadow_w [2];

  int n_checks;
  int n_errors;

  // Model state: pending write per instance is {winner, merged data} in exp_q.
  logic [DW:0]   exp_q0[$];
  logic [DW:0]   exp_q1[$];
  logic [DW-1:0] m_shadow [2];
  int            m_last [2];
  int            m_wait [2];

  pio_write_arbiter #(.DW(DW), .PRIO_MODE(0), .STARVE_LIM(8)) dut_rr (
    .clk(clk), .rst(rst),
    .req0(req0_a[0]), .data0(data0_a[0]), .mask0(mask0_a[0]),
    .req1(req1_a[0]), .data1(data1_a[0]), .mask1(mask1_a[0]),
    .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .pio_en(pio_en_w[0]),
    .pio_data(pio_data_w[0]), .shadow(shadow_w[0]), .busy(busy_w[0])
  );

  pio_write_arbiter #(.DW(DW), .PRIO_MODE(1), .STARVE_LIM(LIM)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0_a[1]), .data0(data0_a[1]), .mask0(mask0_a[1]),
    .req1(req1_a[1]), .data1(data1_a[1]), .mask1(mask1_a[1]),
    .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .pio_en(pio_en_w[1]),
    .pio_data(pio_data_w[1]), .shadow(shadow_w[1]), .busy(busy_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < MW; b++)
      if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [DW:0] q_front(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic logic [DW:0] q_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic q_push(input int d, input logic [DW:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_shadow[d] = '0;
      m_last[d]   = 1;
      m_wait[d]   = 0;
    end
  endtask

  task automatic check_dut(input int d);
    logic [DW:0] e;
    logic        wr;
    wr = (q_size(d) > 0);
    e  = wr ? q_front(d) : '0;
    check($sformatf("d%0d_pio_en", d), 64'(pio_en_w[d]), 64'(wr));
    check($sformatf("d%0d_busy", d), 64'(busy_w[d]), 64'(wr));
    check($sformatf("d%0d_gnt0", d), 64'(gnt0_w[d]), 64'(wr && !e[DW]));
    check($sformatf("d%0d_gnt1", d), 64'(gnt1_w[d]), 64'(wr && e[DW]));
    check($sformatf("d%0d_pio_data", d), 64'(pio_data_w[d]), 64'(wr ? e[DW-1:0] : '0));
    check($sformatf("d%0d_shadow", d), 64'(shadow_w[d]), 64'(m_shadow[d]));
    check($sformatf("d%0d_double_gnt", d), 64'(gnt0_w[d] & gnt1_w[d]), 64'(0));
  endtask

  // Applies the rules for the coming rising edge given the inputs now driven.
  task automatic advance(input int d);
    logic [DW:0] e;
    logic        r0, r1, g1;
    int          win;
    r0 = req0_a[d];
    r1 = req1_a[d];
    g1 = 1'b0;
    if (q_size(d) > 0) begin
      e           = q_pop(d);
      m_shadow[d] = e[DW-1:0];
      m_last[d]   = e[DW] ? 1 : 0;
      g1          = e[DW];
    end else if (r0 || r1) begin
      if (d == 0) win = (r0 && r1) ? 1 - m_last[d] : (r1 ? 1 : 0);
      else        win = (r1 && (!r0 || m_wait[d] == LIM)) ? 1 : 0;
      q_push(d, {win[0], merge(m_shadow[d], win[0] ? data1_a[d] : data0_a[d],
                               win[0] ? mask1_a[d] : mask0_a[d])});
    end
    if (!r1 || g1)          m_wait[d] = 0;
    else if (m_wait[d] < LIM) m_wait[d]++;
  endtask

  task automatic cycle();
    for (int d = 0; d < 2; d++) check_dut(d);
    for (int d = 0; d < 2; d++) advance(d);
    @(negedge clk);
  endtask

  // driver: a granted or idle requester may (re)request; a waiting one holds
  task automatic drive_rand(input int d);
    logic [DW:0] e;
    logic        wr;
    logic        nxt;
    wr = (q_size(d) > 0);
    e  = wr ? q_front(d) : '0;
    for (int r = 0; r < 2; r++) begin
      logic cur, granted;
      cur     = (r == 0) ? req0_a[d] : req1_a[d];
      granted = wr && (e[DW] == r[0]);
      if (!cur || granted) nxt = ($urandom_range(0, 99) < 60);
      else                 nxt = 1'b1;
      if (r == 0) begin
        req0_a[d]  = nxt;
        data0_a[d] = $urandom;
        mask0_a[d] = MW'($urandom_range(0, 15));
      end else begin
        req1_a[d]  = nxt;
        data1_a[d] = $urandom;
        mask1_a[d] = MW'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    int order[$];
    int exp_rr[4];
    int exp_fp[6];
    exp_rr = '{0, 1, 0, 1};
    exp_fp = '{0, 0, 1, 0, 0, 1};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req0_a[d] = 1'b0; req1_a[d] = 1'b0;
      data0_a[d] = '0;  data1_a[d] = '0;
      mask0_a[d] = '0;  mask1_a[d] = '0;
    end
    model_reset();

    // reset then idle
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) cycle();

    // single full write
    req0_a[0] = 1'b1; data0_a[0] = 32'hA5A5_1234; mask0_a[0] = 4'hF;
    cycle();
    check("full_pio_data", 64'(pio_data_w[0]), 64'(32'hA5A5_1234));
    check("full_gnt0", 64'(gnt0_w[0]), 64'(1));
    req0_a[0] = 1'b0;
    cycle();
    cycle();
    check("full_shadow", 64'(shadow_w[0]), 64'(32'hA5A5_1234));

    // byte merge
    req1_a[0] = 1'b1; data1_a[0] = 32'hFFFF_FFFF; mask1_a[0] = 4'h2;
    cycle();
    check("merge_pio_data", 64'(pio_data_w[0]), 64'(32'hA5A5_FF34));
    check("merge_gnt1", 64'(gnt1_w[0]), 64'(1));
    req1_a[0] = 1'b0;
    cycle();
    cycle();

    // round-robin contention
    req0_a[0] = 1'b1; data0_a[0] = 32'h0000_1111; mask0_a[0] = 4'h3;
    req1_a[0] = 1'b1; data1_a[0] = 32'h2222_0000; mask1_a[0] = 4'hC;
    order.delete();
    repeat (8) begin
      cycle();
      if (pio_en_w[0]) order.push_back(gnt1_w[0] ? 1 : 0);
    end
    req0_a[0] = 1'b0; req1_a[0] = 1'b0;
    cycle();
    check("rr_writes", 64'(order.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(exp_rr[i]));

    // starvation in fixed priority
    req0_a[1] = 1'b1; data0_a[1] = 32'h1357_9BDF; mask0_a[1] = 4'hF;
    req1_a[1] = 1'b1; data1_a[1] = 32'h0F0F_0F0F; mask1_a[1] = 4'h5;
    order.delete();
    repeat (12) begin
      cycle();
      if (pio_en_w[1]) order.push_back(gnt1_w[1] ? 1 : 0);
    end
    req0_a[1] = 1'b0; req1_a[1] = 1'b0;
    cycle();
    check("fp_writes", 64'(order.size()), 64'(6));
    for (int i = 0; i < 6; i++)
      if (i < order.size()) check($sformatf("fp_order%0d", i), 64'(order[i]), 64'(exp_fp[i]));

    // reset during a write
    req0_a[0] = 1'b1; data0_a[0] = 32'h1234_5678; mask0_a[0] = 4'h5;
    cycle();
    check("pre_rst_pio_en", 64'(pio_en_w[0]), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_pio_en", 64'(pio_en_w[0]), 64'(0));
    check("rst_gnt0", 64'(gnt0_w[0]), 64'(0));
    check("rst_busy", 64'(busy_w[0]), 64'(0));
    check("rst_shadow", 64'(shadow_w[0]), 64'(0));
    check("rst_pio_data", 64'(pio_data_w[0]), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    check("post_rst_pio_data", 64'(pio_data_w[0]), 64'(32'h0034_0078));
    check("post_rst_gnt0", 64'(gnt0_w[0]), 64'(1));
    req0_a[0] = 1'b0;
    cycle();
    cycle();

    // random traffic on both instances
    repeat (3000) begin
      for (int d = 0; d < 2; d++) drive_rand(d);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
